udc_param: RTL and testbench

Parametrised up/down counter, the successor to the fixed 8-bit `udc`. It adds configurable width and modulus, wrap or saturate mode, synchronous load and clear, count enable, a terminal-count pulse and sticky overflow/underflow flags. It serves as the general counting primitive for timers, address generators and event tallies in the design. All outputs are registered.

---
 rtl/udc_pkg.sv | 6 +
 rtl/udc_next.sv | 29 ++
 rtl/udc_param.sv | 48 ++++
 tb/tb_udc_param.sv | 128 ++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// udc_pkg: shared constants and operation decode for the parametrised up/down counter
package udc_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
  typedef enum logic [2:0] {OP_HOLD, OP_CLR, OP_LOAD, OP_UP, OP_DOWN} op_t;
endpackage

// File: rtl/udc_next.sv
// udc_next: combinational next-count and boundary-event logic for the counter
module udc_next
  import udc_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_VAL   = 2**WIDTH-1,
  parameter int          MODE      = MODE_WRAP,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic [WIDTH-1:0] count,
  input  op_t              op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             at_top_event,
  output logic             at_bot_event
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] clamp_val, up_val, dn_val;
  assign at_top_event = (op == OP_UP) && (count == MAX);
  assign at_bot_event = (op == OP_DOWN) && (count == '0);
  assign clamp_val = (load_val > MAX) ? MAX : load_val;
  assign up_val = (count == MAX) ? ((MODE == MODE_SAT) ? MAX : '0) : count + WIDTH'(1);
  assign dn_val = (count == '0) ? ((MODE == MODE_SAT) ? '0 : MAX) : count - WIDTH'(1);
  assign next_count = (op == OP_CLR)  ? RST :
                      (op == OP_LOAD) ? clamp_val :
                      (op == OP_UP)   ? up_val :
                      (op == OP_DOWN) ? dn_val : count;
endmodule

// File: rtl/udc_param.sv
// udc_param: parametrised up/down counter with wrap/saturate, load, clear and sticky flags
module udc_param
  import udc_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_VAL   = 2**WIDTH-1,
  parameter int          MODE      = MODE_WRAP,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
  op_t              op;
  logic [WIDTH-1:0] next_count;
  logic             top_ev, bot_ev;
  assign op = clr ? OP_CLR : load ? OP_LOAD : en ? (up_down ? OP_UP : OP_DOWN) : OP_HOLD;
  udc_next #(
    .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .MODE(MODE), .RESET_VAL(RESET_VAL)
  ) u_next (
    .count(count), .op(op), .load_val(load_val),
    .next_count(next_count), .at_top_event(top_ev), .at_bot_event(bot_ev)
  );
  // count register, one-cycle tc pulse on boundary steps, sticky flags where set beats flag_clr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RST;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= next_count;
      tc    <= top_ev | bot_ev;
      ovf   <= top_ev | (ovf & ~flag_clr);
      unf   <= bot_ev | (unf & ~flag_clr);
    end
  end
endmodule

// File: tb/tb_udc_param.sv
// tb_udc_param: directed self-checking bench for udc_param in default, wrap-9 and saturate-9 configurations
module tb_udc_param;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, up_down = 1'b0, load = 1'b0, clr = 1'b0, flag_clr = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] c8, cw, cs;
  logic t8, o8, u8, tw, ow, uw, ts, os, us;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  udc_param u_d8 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clr(clr), .flag_clr(flag_clr), .count(c8), .tc(t8), .ovf(o8), .unf(u8)
  );
  udc_param #(.WIDTH(8), .MAX_VAL(9), .MODE(0), .RESET_VAL(3)) u_w9 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clr(clr), .flag_clr(flag_clr), .count(cw), .tc(tw), .ovf(ow), .unf(uw)
  );
  udc_param #(.WIDTH(8), .MAX_VAL(9), .MODE(1), .RESET_VAL(0)) u_s9 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clr(clr), .flag_clr(flag_clr), .count(cs), .tc(ts), .ovf(os), .unf(us)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (c8 !== 8'd0) begin n_err++; $display("FAIL reset_c8: got %0d want 0", c8); end
    n_cmp++; if (cw !== 8'd3) begin n_err++; $display("FAIL reset_cw: got %0d want 3", cw); end
    n_cmp++; if ({t8, o8, u8, tw, ow, uw, ts, os, us} !== 9'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0", {t8, o8, u8, tw, ow, uw, ts, os, us}); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_count_up();
    en = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_cmp++; if (c8 !== 8'(i)) begin n_err++; $display("FAIL up_count[%0d]: got %0d want %0d", i, c8, i); end
      n_cmp++; if ({t8, o8, u8} !== 3'b0) begin n_err++; $display("FAIL up_flags[%0d]: got %b want 000", i, {t8, o8, u8}); end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    load = 1'b1; load_val = 8'd8; step(); load = 1'b0;
    n_cmp++; if (cw !== 8'd8) begin n_err++; $display("FAIL wrap_load: got %0d want 8", cw); end
    en = 1'b1; up_down = 1'b1;
    step();
    n_cmp++; if ({cw, tw} !== {8'd9, 1'b0}) begin n_err++; $display("FAIL wrap_up9: got %0d/%b want 9/0", cw, tw); end
    step();
    n_cmp++; if ({cw, tw, ow} !== {8'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL wrap_up0: got %0d/%b/%b want 0/1/1", cw, tw, ow); end
    step();
    n_cmp++; if ({cw, tw, ow} !== {8'd1, 1'b0, 1'b1}) begin n_err++; $display("FAIL wrap_up1: got %0d/%b/%b want 1/0/1", cw, tw, ow); end
    en = 1'b0; load = 1'b1; load_val = 8'd0; step(); load = 1'b0;
    n_cmp++; if ({cw, tw} !== {8'd0, 1'b0}) begin n_err++; $display("FAIL wrap_load0: got %0d/%b want 0/0", cw, tw); end
    en = 1'b1; up_down = 1'b0; step(); en = 1'b0;
    n_cmp++; if ({cw, tw, uw} !== {8'd9, 1'b1, 1'b1}) begin n_err++; $display("FAIL wrap_down: got %0d/%b/%b want 9/1/1", cw, tw, uw); end
    step();
    n_cmp++; if ({cw, tw} !== {8'd9, 1'b0}) begin n_err++; $display("FAIL wrap_tc_drop: got %0d/%b want 9/0", cw, tw); end
  endtask

  task automatic test_saturate();
    flag_clr = 1'b1; step(); flag_clr = 1'b0;
    n_cmp++; if ({os, us} !== 2'b00) begin n_err++; $display("FAIL flagclr_noevt: got %b want 00", {os, us}); end
    load = 1'b1; load_val = 8'd9; step(); load = 1'b0;
    en = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({cs, ts, os} !== {8'd9, 1'b1, 1'b1}) begin n_err++; $display("FAIL sat_up[%0d]: got %0d/%b/%b want 9/1/1", i, cs, ts, os); end
    end
    en = 1'b0; step();
    n_cmp++; if (ts !== 1'b0) begin n_err++; $display("FAIL sat_tc_drop: got %b want 0", ts); end
    load = 1'b1; load_val = 8'd0; step(); load = 1'b0;
    en = 1'b1; up_down = 1'b0; step(); en = 1'b0;
    n_cmp++; if ({cs, ts, us} !== {8'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL sat_down: got %0d/%b/%b want 0/1/1", cs, ts, us); end
  endtask

  task automatic test_priority();
    clr = 1'b1; load = 1'b1; load_val = 8'd5; en = 1'b1; up_down = 1'b1; step();
    clr = 1'b0; en = 1'b0;
    n_cmp++; if ({cw, tw} !== {8'd3, 1'b0}) begin n_err++; $display("FAIL prio_clr: got %0d/%b want 3/0", cw, tw); end
    n_cmp++; if (ow !== 1'b1) begin n_err++; $display("FAIL prio_clr_keeps_ovf: got %b want 1", ow); end
    load_val = 8'd200; step(); load = 1'b0;
    n_cmp++; if ({cw, cs, c8} !== {8'd9, 8'd9, 8'd200}) begin n_err++; $display("FAIL load_clamp: got %0d/%0d/%0d want 9/9/200", cw, cs, c8); end
  endtask

  task automatic test_flags();
    flag_clr = 1'b1; en = 1'b1; up_down = 1'b1; step(); en = 1'b0;
    n_cmp++; if ({cw, tw, ow, uw} !== {8'd0, 1'b1, 1'b1, 1'b0}) begin n_err++; $display("FAIL flagclr_wrap: got %0d/%b/%b/%b want 0/1/1/0", cw, tw, ow, uw); end
    step(); flag_clr = 1'b0;
    n_cmp++; if ({ow, uw} !== 2'b00) begin n_err++; $display("FAIL flagclr_plain: got %b want 00", {ow, uw}); end
  endtask

  task automatic test_async_reset();
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b1; up_down = 1'b0; step();
    n_cmp++; if ({c8, t8, u8} !== {8'd255, 1'b1, 1'b1}) begin n_err++; $display("FAIL d8_underflow: got %0d/%b/%b want 255/1/1", c8, t8, u8); end
    en = 1'b0; load = 1'b1; load_val = 8'd6; step(); load = 1'b0;
    en = 1'b1; up_down = 1'b1; step();
    n_cmp++; if ({c8, u8} !== {8'd7, 1'b1}) begin n_err++; $display("FAIL pre_reset: got %0d/%b want 7/1", c8, u8); end
    #3 reset = 1'b0;
    #1;
    n_cmp++; if ({c8, t8, o8, u8} !== {8'd0, 3'b000}) begin n_err++; $display("FAIL async_reset: got %0d/%b%b%b want 0/000", c8, t8, o8, u8); end
    n_cmp++; if (cw !== 8'd3) begin n_err++; $display("FAIL async_reset_cw: got %0d want 3", cw); end
    step();
    n_cmp++; if (c8 !== 8'd0) begin n_err++; $display("FAIL reset_hold: got %0d want 0", c8); end
    reset = 1'b1;
    step();
    n_cmp++; if (c8 !== 8'd1) begin n_err++; $display("FAIL resume: got %0d want 1", c8); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate();
    test_priority();
    test_flags();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
